perf_monitor: RTL and testbench

- Parametrised, synthesisable successor to the bench-only ISA-test statistics logic.
- Counts cycles, retired instructions, control-flow instructions, mispredictions and N_EVT generic pipeline events.
- Counting is confined to a PC-delimited measurement window and sits beside the pipeline core, driven from its writeback/retire debug outputs.
- Results are read through a registered address/data port, so both the bench and an MMIO wrapper can read them.

---
 rtl/perf_monitor.sv | 172 +++++++++++++++++
 tb/tb_perf_monitor.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_monitor.sv
// -----------------------------------------------------------------------------
// perf_monitor
//
// Measurement-window performance counters that sit beside the pipeline core.
// They are driven from its writeback/retire debug outputs. Counting covers a
// window that opens when PC_START retires and closes when PC_STOP retires.
// Both the opening and the closing instruction are counted. Results are read
// through a registered address/data port with one cycle of latency.
//
// Channel map:
//   0 : cycles in the window
//   1 : retired instructions
//   2 : retired control-flow instructions (branch/jump)
//   3 : resolved mispredictions
//   4+k : generic event i_evt[k]
//   An address >= NCH reads 0.
//
// Ports:
//   i_clk        clock
//   i_reset      synchronous, active-high reset
//   i_pc         PC of the instruction retiring this cycle
//   i_insn_vld   an instruction retired this cycle
//   i_ctrl       the retiring instruction is a branch/jump
//   i_mispred    a misprediction resolved this cycle
//   i_evt        generic event strobes, one per bit
//   i_clear      zero all counters and re-arm the window
//   i_rd_addr    channel select
//   o_rd_data    registered channel value (value before the last edge)
//   o_state      0 = IDLE, 1 = RUN, 2 = DONE
//   o_done       window closed, counters frozen
//   o_sat        sticky: some counter reached all-ones
// -----------------------------------------------------------------------------
module perf_monitor #(
  parameter int          CNT_W      = 32,
  parameter int          N_EVT      = 4,
  parameter logic [31:0] PC_START   = 32'h0000_0000,
  parameter logic [31:0] PC_STOP    = 32'h0000_001C,
  parameter bit          AUTO_START = 1'b0,
  // Derived; do not override.
  parameter int          NCH        = 4 + N_EVT,
  parameter int          RA_W       = $clog2(NCH)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [31:0]      i_pc,
  input  logic             i_insn_vld,
  input  logic             i_ctrl,
  input  logic             i_mispred,
  input  logic [N_EVT-1:0] i_evt,
  input  logic             i_clear,
  input  logic [RA_W-1:0]  i_rd_addr,
  output logic [CNT_W-1:0] o_rd_data,
  output logic [1:0]       o_state,
  output logic             o_done,
  output logic             o_sat
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // State entered from reset and from i_clear.
  localparam state_t ARM_STATE = AUTO_START ? S_RUN : S_IDLE;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt     [NCH];
  logic [CNT_W-1:0] cnt_nxt [NCH];
  logic [NCH-1:0]   hit;
  logic             count_en;
  logic             start_hit, stop_hit;
  logic             any_max;
  logic             sat, sat_nxt;
  logic [CNT_W-1:0] rd_data, rd_nxt;

  assign start_hit = i_insn_vld && (i_pc == PC_START);
  assign stop_hit  = i_insn_vld && (i_pc == PC_STOP);

  // Per-channel increment requests, qualified later by count_en.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    hit                = '0;
    hit[0]             = 1'b1;
    hit[1]             = i_insn_vld;
    hit[2]             = i_ctrl && i_insn_vld;
    hit[3]             = i_mispred;
    hit[NCH-1:4]       = i_evt;
  end

  // Next-state logic. The cycle that opens the window and the cycle that
  // closes it are both counted. In RUN a PC_START match is ignored, so when
  // PC_START == PC_STOP the first hit opens and the second one closes.
  always_comb begin
    state_nxt = state;
    count_en  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start_hit) begin
          state_nxt = S_RUN;
          count_en  = 1'b1;
        end
      end
      S_RUN: begin
        count_en = 1'b1;
        if (stop_hit) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_DONE;
      end
      default: state_nxt = ARM_STATE;
    endcase
    // Clear beats everything except reset, and the clear cycle is not counted.
    if (i_clear) begin
      state_nxt = ARM_STATE;
      count_en  = 1'b0;
    end
  end

  // Saturating counters plus the sticky saturation flag. The flag is computed
  // from the next counter values, so it rises together with the counter that
  // reaches all-ones.
  always_comb begin
    any_max = 1'b0;
    for (int ch = 0; ch < NCH; ch++) begin
      cnt_nxt[ch] = cnt[ch];
      if (i_clear)
        cnt_nxt[ch] = '0;
      else if (count_en && hit[ch] && (cnt[ch] != CNT_MAX))
        cnt_nxt[ch] = cnt[ch] + CNT_W'(1);
      if (cnt_nxt[ch] == CNT_MAX) any_max = 1'b1;
    end
    sat_nxt = i_clear ? 1'b0 : (sat | any_max);
  end

  // Read mux. It uses the current counter values, so the registered output
  // shows each counter as it stood before the edge that captures it.
  // Unmatched addresses fall through to 0.
  always_comb begin
    rd_nxt = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      if (i_rd_addr == RA_W'(ch)) rd_nxt = cnt[ch];
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples values from before the edge and process order does not matter.
    if (i_reset) begin
      state   <= ARM_STATE;
      sat     <= 1'b0;
      rd_data <= '0;
      // NOTE: the counter array is a bank of flops rather than a RAM. It
      // must be reset because a reset in mid-run discards all counts.
      for (int ch = 0; ch < NCH; ch++) cnt[ch] <= '0;
    end else begin
      state   <= state_nxt;
      sat     <= sat_nxt;
      rd_data <= rd_nxt;
      for (int ch = 0; ch < NCH; ch++) cnt[ch] <= cnt_nxt[ch];
    end
  end

  assign o_rd_data = rd_data;
  assign o_state   = state;
  assign o_done    = (state == S_DONE);
  assign o_sat     = sat;

endmodule

// File: tb/tb_perf_monitor.sv
// -----------------------------------------------------------------------------
// tb_perf_monitor
//
// Testbench with two instances:
//   u_dut : default parameters (32-bit counters, 4 events, AUTO_START=0)
//   u_aux : CNT_W=4, N_EVT=3, AUTO_START=1 (saturation, auto-start and
//           out-of-range reads)
//
// Readout expectations are pushed to a scoreboard queue when a read address
// is driven. They are popped and compared when the registered data appears
// one cycle later.
// -----------------------------------------------------------------------------
module tb_perf_monitor;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance signals
  logic        reset, insn_vld, ctrl, mispred, clear;
  logic [31:0] pc;
  logic [3:0]  evt;
  logic [2:0]  rd_addr;
  logic [31:0] rd_data;
  logic [1:0]  state;
  logic        done, sat;

  // Auxiliary instance signals
  logic        a_reset, a_insn_vld, a_ctrl, a_mispred, a_clear;
  logic [31:0] a_pc;
  logic [2:0]  a_evt;
  logic [2:0]  a_rd_addr;
  logic [3:0]  a_rd_data;
  logic [1:0]  a_state;
  logic        a_done, a_sat;

  perf_monitor u_dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_pc       (pc),
    .i_insn_vld (insn_vld),
    .i_ctrl     (ctrl),
    .i_mispred  (mispred),
    .i_evt      (evt),
    .i_clear    (clear),
    .i_rd_addr  (rd_addr),
    .o_rd_data  (rd_data),
    .o_state    (state),
    .o_done     (done),
    .o_sat      (sat)
  );

  perf_monitor #(
    .CNT_W      (4),
    .N_EVT      (3),
    .AUTO_START (1'b1)
  ) u_aux (
    .i_clk      (clk),
    .i_reset    (a_reset),
    .i_pc       (a_pc),
    .i_insn_vld (a_insn_vld),
    .i_ctrl     (a_ctrl),
    .i_mispred  (a_mispred),
    .i_evt      (a_evt),
    .i_clear    (a_clear),
    .i_rd_addr  (a_rd_addr),
    .o_rd_data  (a_rd_data),
    .o_state    (a_state),
    .o_done     (a_done),
    .o_sat      (a_sat)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
    bit          aux;
  } sb_item_t;

  sb_item_t sb_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a read address, queue its expected value, then compare the
  // registered result one cycle later.
  task automatic rd(input bit aux, input logic [2:0] addr, input logic [31:0] exp,
                    input string tag);
    sb_item_t it;
    logic [31:0] got;
    if (aux) a_rd_addr = addr;
    else     rd_addr   = addr;
    it.tag = tag;
    it.exp = exp;
    it.aux = aux;
    sb_q.push_back(it);
    tick();
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      it  = sb_q.pop_front();
      got = it.aux ? {28'd0, a_rd_data} : rd_data;
      check(it.tag, got, it.exp);
    end
  endtask

  task automatic idle_main();
    insn_vld = 1'b0;
    ctrl     = 1'b0;
    mispred  = 1'b0;
    evt      = '0;
    clear    = 1'b0;
    pc       = 32'h0000_0100;
  endtask

  // Window stimulus table: index 0 opens the window (PC 0x0) and index 9
  // closes it (PC 0x1C). Index 8 retires PC 0x0 again while running, and
  // index 2 raises ctrl without a retire.
  logic [9:0]  t_vld  = 10'b11_0100_1011;   // bit i = cycle i
  logic [9:0]  t_ctrl = 10'b10_0000_1101;
  logic [9:0]  t_mis  = 10'b00_0010_0100;
  logic [9:0]  t_evt  = 10'b01_0101_0011;   // evt = 4'b0101 when set
  logic [31:0] t_pc [10];

  logic [31:0] exp_main [8];
  logic [31:0] exp_aux  [8];

  initial begin
    t_pc = '{32'h00, 32'h04, 32'h100, 32'h08, 32'h100,
             32'h100, 32'h0C, 32'h100, 32'h00, 32'h1C};

    idle_main();
    rd_addr    = '0;
    reset      = 1'b1;
    a_reset    = 1'b1;
    a_pc       = 32'h0000_0100;
    a_insn_vld = 1'b0;
    a_ctrl     = 1'b0;
    a_mispred  = 1'b0;
    a_evt      = '0;
    a_clear    = 1'b0;
    a_rd_addr  = '0;
    tick();
    tick();

    // ---- Reset state ----
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sat", {31'd0, sat}, 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("aux_rst_state", {30'd0, a_state}, 32'd1);
    check("aux_rst_rd_data", {28'd0, a_rd_data}, 32'd0);
    reset   = 1'b0;
    a_reset = 1'b0;
    tick();
    rd(1'b0, 3'd0, 32'd0, "idle_cycle_zero");

    // ---- Short window: PCs 0x0, 0x4, 0x8, 0x1C ----
    insn_vld = 1'b1;
    pc = 32'h00; tick();
    check("win_state_run", {30'd0, state}, 32'd1);
    pc = 32'h04; tick();
    pc = 32'h08; tick();
    check("win_done_before_stop", {31'd0, done}, 32'd0);
    pc = 32'h1C; tick();
    check("win_state_done", {30'd0, state}, 32'd2);
    check("win_done", {31'd0, done}, 32'd1);
    // Activity after DONE must be ignored.
    pc = 32'h00; ctrl = 1'b1; mispred = 1'b1; evt = 4'hF;
    tick(); tick(); tick();
    idle_main();
    check("frozen_state", {30'd0, state}, 32'd2);
    exp_main = '{32'd4, 32'd4, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    for (int a = 0; a < 8; a++)
      rd(1'b0, 3'(a), exp_main[a], $sformatf("win_ch%0d", a));

    // ---- Clear together with a stop match while in DONE ----
    clear = 1'b1; insn_vld = 1'b1; pc = 32'h1C;
    tick();
    idle_main();
    check("clr_state", {30'd0, state}, 32'd0);
    check("clr_done", {31'd0, done}, 32'd0);
    check("clr_sat", {31'd0, sat}, 32'd0);
    for (int a = 0; a < 8; a++)
      rd(1'b0, 3'(a), 32'd0, $sformatf("clr_ch%0d", a));

    // ---- IDLE ignores activity that does not match PC_START ----
    insn_vld = 1'b1; pc = 32'h40; ctrl = 1'b1; mispred = 1'b1; evt = 4'hF;
    tick();
    idle_main();
    check("idle_ignore_state", {30'd0, state}, 32'd0);

    // ---- Mixed-activity window of 10 cycles ----
    for (int i = 0; i < 10; i++) begin
      insn_vld = t_vld[i];
      pc       = t_pc[i];
      ctrl     = t_ctrl[i];
      mispred  = t_mis[i];
      evt      = t_evt[i] ? 4'b0101 : 4'b0000;
      tick();
    end
    idle_main();
    check("mix_state_done", {30'd0, state}, 32'd2);
    exp_main = '{32'd10, 32'd6, 32'd3, 32'd2, 32'd5, 32'd0, 32'd5, 32'd0};
    for (int a = 0; a < 8; a++)
      rd(1'b0, 3'(a), exp_main[a], $sformatf("mix_ch%0d", a));
    check("mix_sat", {31'd0, sat}, 32'd0);

    // ---- Reset in the middle of a run ----
    clear = 1'b1; tick(); clear = 1'b0;
    insn_vld = 1'b1; pc = 32'h00; tick();
    idle_main();
    for (int i = 0; i < 6; i++) tick();
    // Seven cycles have been counted; this read returns 7.
    rd(1'b0, 3'd0, 32'd7, "pre_reset_cycle");
    check("pre_reset_state", {30'd0, state}, 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("post_reset_state", {30'd0, state}, 32'd0);
    check("post_reset_done", {31'd0, done}, 32'd0);
    rd(1'b0, 3'd0, 32'd0, "post_reset_cycle");
    rd(1'b0, 3'd1, 32'd0, "post_reset_insn");

    // ---- Aux: saturation, sticky flag and clear ----
    // The aux instance has been running since reset, so it is saturated.
    check("aux_sat_before_clr", {31'd0, a_sat}, 32'd1);
    a_clear = 1'b1; tick(); a_clear = 1'b0;
    check("aux_clr_sat", {31'd0, a_sat}, 32'd0);
    check("aux_clr_state", {30'd0, a_state}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      a_insn_vld = (i < 3);
      a_ctrl     = (i == 0);
      a_mispred  = (i == 5);
      a_evt      = (i < 2) ? 3'b010 : ((i == 4) ? 3'b100 : 3'b000);
      tick();
      check($sformatf("aux_sat_c%0d", i + 1), {31'd0, a_sat}, (i >= 14) ? 32'd1 : 32'd0);
    end
    a_insn_vld = 1'b0; a_ctrl = 1'b0; a_mispred = 1'b0; a_evt = '0;
    // Read sweep including the out-of-range address 7 (NCH = 7).
    exp_aux = '{32'd15, 32'd3, 32'd1, 32'd1, 32'd0, 32'd2, 32'd1, 32'd0};
    for (int a = 0; a < 8; a++)
      rd(1'b1, 3'(a), exp_aux[a], $sformatf("aux_ch%0d", a));
    check("aux_sat_sticky", {31'd0, a_sat}, 32'd1);

    // ---- Aux: reset with AUTO_START restarts counting from 0 ----
    a_reset = 1'b1; tick(); a_reset = 1'b0;
    check("aux_reset_state", {30'd0, a_state}, 32'd1);
    check("aux_reset_sat", {31'd0, a_sat}, 32'd0);
    rd(1'b1, 3'd0, 32'd0, "aux_reset_cycle0");
    rd(1'b1, 3'd0, 32'd1, "aux_reset_cycle1");
    rd(1'b1, 3'd0, 32'd2, "aux_reset_cycle2");

    if (sb_q.size() != 0) check("scoreboard_leftover", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
